// File: rtl/ins_decode_pkg.sv
// Shared decode constants for the single-cycle MIPS-subset decode stage:
// opcode/funct values, ALU control encodings, widths and the immediate extender.
package ins_decode_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_OR  = 3'b010,
        ALU_AND = 3'b011,
        ALU_SLT = 3'b100,
        ALU_LUI = 3'b101
    } alu_ctr_e;

    typedef struct packed {
        logic     reg_dst;
        logic     alu_src;
        logic     mem_to_reg;
        logic     reg_write;
        logic     mem_write;
        logic     branch;
        logic     jump;
        logic     ext_op;
        alu_ctr_e alu_ctr;
        logic     illegal;
    } ctrl_t;

    // ext_op=1 replicates imm[15]; ext_op=0 zero-fills the upper half.
    function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic ext_op);
        extend_imm = {(ext_op ? {16{imm[15]}} : 16'h0000), imm};
    endfunction

endpackage

// File: rtl/ins_decode_if.sv
// Fetch/decode/execute/write-back bus seen by the decode stage.
// master drives the instruction and write-back data; slave is the decoder.
interface ins_decode_if #(parameter int DATA_WIDTH = 32);
    logic [31:0]           Instruction;
    logic [DATA_WIDTH-1:0] busW;
    logic [DATA_WIDTH-1:0] busA;
    logic [DATA_WIDTH-1:0] busB;
    logic [31:0]           ext_imm;
    logic                  RegDst;
    logic                  ALUSrc;
    logic                  MemtoReg;
    logic                  RegWrite;
    logic                  MemWrite;
    logic                  Branch;
    logic                  Jump;
    logic                  ExtOp;
    logic [2:0]            ALUctr;
    logic                  illegal;

    modport master (
        output Instruction, busW,
        input  busA, busB, ext_imm, RegDst, ALUSrc, MemtoReg, RegWrite,
               MemWrite, Branch, Jump, ExtOp, ALUctr, illegal
    );

    modport slave (
        input  Instruction, busW,
        output busA, busB, ext_imm, RegDst, ALUSrc, MemtoReg, RegWrite,
               MemWrite, Branch, Jump, ExtOp, ALUctr, illegal
    );
endinterface

// File: rtl/ins_decode_reg_file.sv
// 2-read/1-write register file: async reads, negedge write, async active-low clear.
// Register 0 always reads zero and silently drops writes.
module ins_decode_reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] ra,
    input  logic [REG_ADDR_W-1:0] rb,
    input  logic [REG_ADDR_W-1:0] rw,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic [DATA_WIDTH-1:0] qa,
    output logic [DATA_WIDTH-1:0] qb
);
    localparam int NREGS = 2 ** REG_ADDR_W;

    logic [DATA_WIDTH-1:0] regs_r [0:NREGS-1];

    // Write on the falling edge, aligned with the PC update in fetch; no read bypass.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we && (rw != '0)) begin
            regs_r[rw] <= wd;
        end
    end

    assign qa = (ra == '0) ? '0 : regs_r[ra];
    assign qb = (rb == '0) ? '0 : regs_r[rb];

endmodule

// File: rtl/ins_decode.sv
// Single-cycle decode stage: combinational control decode from the instruction,
// immediate extension, and the architectural register file.
module ins_decode
    import ins_decode_pkg::*;
#(
    parameter int DATA_WIDTH = ins_decode_pkg::DATA_WIDTH,
    parameter int REG_ADDR_W = ins_decode_pkg::REG_ADDR_W
) (
    input  logic         clk,
    input  logic         reset,
    ins_decode_if.slave  dec
);
    logic [5:0]            opcode_s;
    logic [5:0]            funct_s;
    logic [REG_ADDR_W-1:0] rs_s;
    logic [REG_ADDR_W-1:0] rt_s;
    logic [REG_ADDR_W-1:0] rd_s;
    logic [REG_ADDR_W-1:0] rw_s;
    logic                  unused_shamt_s;
    ctrl_t                 ctrl_s;

    assign opcode_s       = dec.Instruction[31:26];
    assign funct_s        = dec.Instruction[5:0];
    assign rs_s           = dec.Instruction[25:21];
    assign rt_s           = dec.Instruction[20:16];
    assign rd_s           = dec.Instruction[15:11];
    assign unused_shamt_s = ^dec.Instruction[10:6];

    // Control decode; every don't-care is driven 0 and unsupported encodings flag illegal.
    always_comb begin
        ctrl_s = '0;
        case (opcode_s)
            OP_RTYPE: begin
                ctrl_s.reg_dst   = 1'b1;
                ctrl_s.reg_write = 1'b1;
                case (funct_s)
                    FN_ADDU: ctrl_s.alu_ctr = ALU_ADD;
                    FN_SUBU: ctrl_s.alu_ctr = ALU_SUB;
                    FN_AND:  ctrl_s.alu_ctr = ALU_AND;
                    FN_OR:   ctrl_s.alu_ctr = ALU_OR;
                    FN_SLT:  ctrl_s.alu_ctr = ALU_SLT;
                    default: begin
                        ctrl_s         = '0;
                        ctrl_s.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDIU: begin
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.reg_write = 1'b1;
                ctrl_s.ext_op    = 1'b1;
                ctrl_s.alu_ctr   = ALU_ADD;
            end
            OP_ORI: begin
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_ctr   = ALU_OR;
            end
            OP_LUI: begin
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_ctr   = ALU_LUI;
            end
            OP_LW: begin
                ctrl_s.alu_src    = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.ext_op     = 1'b1;
                ctrl_s.alu_ctr    = ALU_ADD;
            end
            OP_SW: begin
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.mem_write = 1'b1;
                ctrl_s.ext_op    = 1'b1;
                ctrl_s.alu_ctr   = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl_s.branch  = 1'b1;
                ctrl_s.ext_op  = 1'b1;
                ctrl_s.alu_ctr = ALU_SUB;
            end
            OP_J: begin
                ctrl_s.jump = 1'b1;
            end
            default: begin
                ctrl_s.illegal = 1'b1;
            end
        endcase
    end

    assign rw_s = ctrl_s.reg_dst ? rd_s : rt_s;

    ins_decode_reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_reg_file (
        .clk   (clk),
        .reset (reset),
        .ra    (rs_s),
        .rb    (rt_s),
        .rw    (rw_s),
        .we    (ctrl_s.reg_write),
        .wd    (dec.busW),
        .qa    (dec.busA),
        .qb    (dec.busB)
    );

    assign dec.ext_imm  = extend_imm(dec.Instruction[15:0], ctrl_s.ext_op);
    assign dec.RegDst   = ctrl_s.reg_dst;
    assign dec.ALUSrc   = ctrl_s.alu_src;
    assign dec.MemtoReg = ctrl_s.mem_to_reg;
    assign dec.RegWrite = ctrl_s.reg_write;
    assign dec.MemWrite = ctrl_s.mem_write;
    assign dec.Branch   = ctrl_s.branch;
    assign dec.Jump     = ctrl_s.jump;
    assign dec.ExtOp    = ctrl_s.ext_op;
    assign dec.ALUctr   = ctrl_s.alu_ctr;
    assign dec.illegal  = ctrl_s.illegal;

endmodule

// File: tb/tb_ins_decode.sv
// Directed-vector bench for ins_decode: control decode, immediate extension,
// negedge register writes, R0 behaviour and asynchronous reset.
module tb_ins_decode;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    ins_decode_if #(.DATA_WIDTH(32)) bus ();

    ins_decode u_dut (
        .clk   (clk),
        .reset (reset),
        .dec   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bundle: RegDst,ALUSrc,MemtoReg,RegWrite,MemWrite,Branch,Jump,ExtOp,ALUctr[2:0],illegal
    logic [11:0] ctrl_s;
    assign ctrl_s = {bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemWrite,
                     bus.Branch, bus.Jump, bus.ExtOp, bus.ALUctr, bus.illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Read-only probe: opcode 111111 is illegal, so nothing is written while reading rs/rt.
    function automatic logic [31:0] rd_ins(input logic [4:0] rs, input logic [4:0] rt);
        rd_ins = {6'b111111, rs, rt, 16'h0000};
    endfunction

    // Drive one instruction just after a rising edge and check its combinational decode.
    task automatic apply(input string tag, input logic [31:0] ins, input logic [31:0] wdata,
                         input logic [11:0] exp_ctrl, input logic [31:0] exp_imm);
        @(posedge clk);
        #1;
        bus.Instruction = ins;
        bus.busW        = wdata;
        #1;
        check({tag, "_ctrl"}, {20'h00000, ctrl_s}, {20'h00000, exp_ctrl});
        check({tag, "_imm"}, bus.ext_imm, exp_imm);
    endtask

    task automatic after_negedge();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_vec           = 0;
        n_err           = 0;
        reset           = 1'b0;
        bus.Instruction = rd_ins(5'd5, 5'd5);
        bus.busW        = 32'h0000_0000;
        #2;
        check("rst_busA", bus.busA, 32'h0000_0000);
        check("rst_busB", bus.busB, 32'h0000_0000);
        check("rst_illegal", {31'h0, bus.illegal}, 32'h0000_0001);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset pulsed low across the write edge must abort the addiu write.
        #1;
        bus.Instruction = 32'h2405_FFFF;
        bus.busW        = 32'hFFFF_FFFF;
        #1;
        reset = 1'b0;
        #1;
        check("midrst_regwrite", {31'h0, bus.RegWrite}, 32'h0000_0001);
        @(negedge clk);
        #2;
        bus.Instruction = rd_ins(5'd5, 5'd5);
        reset = 1'b1;
        #1;
        check("midrst_r5", bus.busA, 32'h0000_0000);

        // addiu $5,$0,0xFFFF: old value before the falling edge, new value after.
        apply("addiu", 32'h2405_FFFF, 32'hFFFF_FFFF, 12'b0_1_0_1_0_0_0_1_000_0, 32'hFFFF_FFFF);
        check("addiu_r5_old", bus.busB, 32'h0000_0000);
        after_negedge();
        check("addiu_r5_new", bus.busB, 32'hFFFF_FFFF);

        // ori $6,$0,0x8000
        apply("ori", 32'h3406_8000, 32'h0000_8000, 12'b0_1_0_1_0_0_0_0_010_0, 32'h0000_8000);
        after_negedge();
        check("ori_r6", bus.busB, 32'h0000_8000);

        // addu $0,$5,$5 with busW=7: R0 must stay zero.
        apply("addu", 32'h00A5_0021, 32'h0000_0007, 12'b1_0_0_1_0_0_0_0_000_0, 32'h0000_0021);
        after_negedge();
        apply("rd_r0", rd_ins(5'd0, 5'd5), 32'h0000_0000, 12'b0_0_0_0_0_0_0_0_000_1, 32'h0000_0000);
        check("r0_zero", bus.busA, 32'h0000_0000);
        check("r5_keep", bus.busB, 32'hFFFF_FFFF);

        // subu $7,$5,$6 writes rd=7.
        apply("subu", 32'h00A6_3823, 32'h1234_5678, 12'b1_0_0_1_0_0_0_0_001_0, 32'h0000_3823);
        after_negedge();
        apply("rd_r7", rd_ins(5'd7, 5'd6), 32'h0000_0000, 12'b0_0_0_0_0_0_0_0_000_1, 32'h0000_0000);
        check("r7_subu", bus.busA, 32'h1234_5678);

        apply("and", 32'h00A6_4024, 32'h0000_0011, 12'b1_0_0_1_0_0_0_0_011_0, 32'h0000_4024);
        apply("or",  32'h00A6_5025, 32'h0000_0022, 12'b1_0_0_1_0_0_0_0_010_0, 32'h0000_5025);
        apply("slt", 32'h00A6_482A, 32'h0000_0001, 12'b1_0_0_1_0_0_0_0_100_0, 32'h0000_482A);
        after_negedge();
        apply("rd_r9", rd_ins(5'd9, 5'd8), 32'h0000_0000, 12'b0_0_0_0_0_0_0_0_000_1, 32'h0000_0000);
        check("r9_slt", bus.busA, 32'h0000_0001);
        check("r8_and", bus.busB, 32'h0000_0011);

        // beq $5,$6,-2: no write to R6 despite busW activity.
        apply("beq", 32'h10A6_FFFE, 32'h0000_DEAD, 12'b0_0_0_0_0_1_0_1_001_0, 32'hFFFF_FFFE);
        check("beq_busA", bus.busA, 32'hFFFF_FFFF);
        after_negedge();
        check("beq_r6", bus.busB, 32'h0000_8000);

        apply("j", 32'h0800_0010, 32'h0000_BEEF, 12'b0_0_0_0_0_0_1_0_000_0, 32'h0000_0010);

        // sw $6,4($5)
        apply("sw", 32'hACA6_0004, 32'h0000_5555, 12'b0_1_0_0_1_0_0_1_000_0, 32'h0000_0004);
        after_negedge();
        check("sw_r6", bus.busB, 32'h0000_8000);

        // lw $11,8($5): destination is rt.
        apply("lw", 32'h8CAB_0008, 32'hCAFE_F00D, 12'b0_1_1_1_0_0_0_1_000_0, 32'h0000_0008);
        after_negedge();
        check("lw_r11", bus.busB, 32'hCAFE_F00D);

        apply("lui", 32'h3C0C_1234, 32'h1234_0000, 12'b0_1_0_1_0_0_0_0_101_0, 32'h0000_1234);

        // Unsupported opcode and unsupported R-type funct (rd=5) leave R5 alone.
        apply("ill_op", 32'hFCA5_0000, 32'h0000_0000, 12'b0_0_0_0_0_0_0_0_000_1, 32'h0000_0000);
        after_negedge();
        check("ill_op_r5", bus.busA, 32'hFFFF_FFFF);
        apply("ill_fn", 32'h00A6_2800, 32'h0000_0000, 12'b0_0_0_0_0_0_0_0_000_1, 32'h0000_2800);
        after_negedge();
        check("ill_fn_r5", bus.busA, 32'hFFFF_FFFF);

        // Async reset clears the file immediately, without waiting for an edge.
        #1;
        reset = 1'b0;
        #1;
        check("rst2_r5", bus.busA, 32'h0000_0000);
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
